// File: rtl/alu_sequencer_if.sv
// Request and writeback channels between the control unit and alu_sequencer.
// master = control unit / register-file side, slave = alu_sequencer.
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_opcode;
    logic [7:0] req_op1;
    logic [7:0] req_op2;
    logic       req_bit;
    logic [7:0] psw_in;

    logic       wb_valid;
    logic [7:0] wb_acc;
    logic [7:0] wb_b;
    logic       wb_b_we;
    logic [7:0] wb_psw;
    logic       wb_psw_we;

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, req_bit, psw_in,
        input  req_ready,
        input  wb_valid, wb_acc, wb_b, wb_b_we, wb_psw, wb_psw_we
    );

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, req_bit, psw_in,
        output req_ready,
        output wb_valid, wb_acc, wb_b, wb_b_we, wb_psw, wb_psw_we
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for alu_core: latches one request, holds the ALU
// inputs stable for the op's hold time, then returns ACC/B/PSW writeback data.
module alu_sequencer #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset,
    alu_sequencer_if.slave bus,
    output logic [3:0]     alu_opcode,
    output logic [7:0]     alu_op1,
    output logic [7:0]     alu_op2,
    output logic           alu_carry_in,
    output logic           alu_aux_carry_in,
    output logic           alu_bit_in,
    input  logic [7:0]     alu_res1,
    input  logic [7:0]     alu_res2,
    input  logic           alu_carry,
    input  logic           alu_aux_carry,
    input  logic           alu_overflow,
    output logic           busy
);

    // ALU opcode encodings shared with alu_core
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDC = 4'd1;
    localparam logic [3:0] ALU_SUBB = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd5;
    localparam logic [3:0] ALU_DIV  = 4'd6;
    localparam logic [3:0] ALU_RRC  = 4'd11;
    localparam logic [3:0] ALU_RLC  = 4'd12;
    localparam logic [3:0] ALU_ORL  = 4'd13;
    localparam logic [3:0] ALU_ANL  = 4'd14;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       psw_lat;
    logic             accept;
    logic             is_muldiv;
    logic [7:0]       psw_c;
    logic             psw_we_c;
    logic             b_we_c;

    assign bus.req_ready = (state == IDLE) || (state == DONE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_muldiv     = (alu_opcode == ALU_MUL) || (alu_opcode == ALU_DIV);

    // Per-op PSW merge; parity (bit0) always comes from the latched PSW
    always_comb begin
        psw_c    = psw_lat;
        psw_we_c = 1'b0;
        b_we_c   = 1'b0;
        case (alu_opcode)
            ALU_ADD, ALU_ADDC, ALU_SUBB: begin
                psw_c[7] = alu_carry;
                psw_c[6] = alu_aux_carry;
                psw_c[2] = alu_overflow;
                psw_we_c = 1'b1;
            end
            ALU_MUL, ALU_DIV: begin
                psw_c[7] = 1'b0;
                psw_c[2] = alu_overflow;
                psw_we_c = 1'b1;
                b_we_c   = 1'b1;
            end
            ALU_RRC, ALU_RLC, ALU_ORL, ALU_ANL: begin
                psw_c[7] = alu_carry;
                psw_we_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            psw_lat          <= '0;
            alu_opcode       <= '0;
            alu_op1          <= '0;
            alu_op2          <= '0;
            alu_carry_in     <= 1'b0;
            alu_aux_carry_in <= 1'b0;
            alu_bit_in       <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_acc       <= '0;
            bus.wb_b         <= '0;
            bus.wb_b_we      <= 1'b0;
            bus.wb_psw       <= '0;
            bus.wb_psw_we    <= 1'b0;
            busy             <= 1'b0;
        end else begin
            bus.wb_valid  <= 1'b0;
            bus.wb_b_we   <= 1'b0;
            bus.wb_psw_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (is_muldiv && (MULDIV_CYCLES > 1)) begin
                        wait_cnt <= CNT_W'(MULDIV_CYCLES - 1);
                        state    <= WAIT;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    bus.wb_acc    <= alu_res1;
                    bus.wb_b      <= alu_res2;
                    bus.wb_psw    <= psw_c;
                    bus.wb_b_we   <= b_we_c;
                    bus.wb_psw_we <= psw_we_c;
                    bus.wb_valid  <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (accept) begin
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Operands are taken only at the accept edge and then held
            if (accept) begin
                alu_opcode       <= bus.req_opcode;
                alu_op1          <= bus.req_op1;
                alu_op2          <= bus.req_op2;
                alu_carry_in     <= bus.psw_in[7];
                alu_aux_carry_in <= bus.psw_in[6];
                alu_bit_in       <= bus.req_bit;
                psw_lat          <= bus.psw_in;
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback controller on the requesting side of alu_core.
- Accepts one decoded ALU request from the control unit via valid/ready.
- Drives alu_core's opcode, operand and flag inputs, holds them stable for the required cycles, then captures op_out_1/op_out_2 and the flag outputs.
- Returns accumulator, B and PSW writeback data as a one-cycle wb_valid pulse. Sits between instruction decode and the ACC/B/PSW register file.

Parameters:
- MULDIV_CYCLES, 4: total ALU hold cycles (ISSUE plus WAIT) for ALU_MUL/ALU_DIV; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_opcode  in  4  ALU opcode, `ALU_* encodings from 8051_define.v
- req_op1  in  8  first operand (usually ACC)
- req_op2  in  8  second operand
- req_bit  in  1  bit operand for ORL/ANL C,bit
- psw_in  in  8  current PSW; CY=bit7, AC=bit6, OV=bit2
- alu_opcode  out  4  to alu_core alu_opcode
- alu_op1  out  8  to op_in_1
- alu_op2  out  8  to op_in_2
- alu_carry_in  out  1  to carry_in
- alu_aux_carry_in  out  1  to aux_carry_in
- alu_bit_in  out  1  to bit_in
- alu_res1  in  8  from op_out_1
- alu_res2  in  8  from op_out_2
- alu_carry  in  1  from carry_out
- alu_aux_carry  in  1  from aux_carry_out
- alu_overflow  in  1  from overflow_out
- wb_valid  out  1  one-cycle writeback strobe
- wb_acc  out  8  result for ACC
- wb_b  out  8  result for B
- wb_b_we  out  1  B write enable, qualified by wb_valid
- wb_psw  out  8  updated PSW
- wb_psw_we  out  1  PSW write enable, qualified by wb_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, wait counter=0.
  - All alu_* outputs, wb_* outputs and busy = 0.
  - req_ready = 1 while in IDLE, including during reset.
  - Reset mid-operation aborts the operation with no wb_valid.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- req_ready is combinational: 1 in IDLE and DONE, 0 otherwise.
- IDLE: on accept, latch req_* and psw_in into alu_* registers:
  - alu_carry_in = psw_in[7]
  - alu_aux_carry_in = psw_in[6]
  - alu_bit_in = req_bit
  - next state ISSUE.
- ISSUE: 1 cycle; alu_core samples inputs at the end of this cycle.
  - MUL/DIV with MULDIV_CYCLES>1: load counter with MULDIV_CYCLES-1, go to WAIT.
  - All other ops: go to CAPTURE.
- WAIT: decrement counter; go to CAPTURE when counter reaches 1.
- alu_* outputs stay constant from ISSUE through CAPTURE. alu_core re-evaluates every edge, so its results must be invariant.
- CAPTURE: at the end of the cycle, register the outputs:
  - wb_acc = alu_res1.
  - wb_b = alu_res2.
  - wb_psw = latched psw with per-op replacement:
    - ADD/ADDC/SUBB: bit7=alu_carry, bit6=alu_aux_carry, bit2=alu_overflow; psw_we=1.
    - MUL/DIV: bit7=0, bit2=alu_overflow; psw_we=1; b_we=1.
    - RRC/RLC/ORL/ANL: bit7=alu_carry; psw_we=1.
    - All other or undefined opcodes: psw unchanged; psw_we=0; b_we=0.
  - Bit0 (parity) is never modified.
- DONE: wb_valid=1 for exactly one cycle.
  - Accept in DONE goes to ISSUE (back-to-back).
  - Otherwise go to IDLE.
  - wb_valid, wb_b_we and wb_psw_we drop to 0 after DONE; wb data holds its last value.
- Latency from accept edge to wb_valid cycle:
  - Non-MUL/DIV ops: 3 cycles.
  - MUL/DIV: 2+MULDIV_CYCLES cycles (6 at default).
  - Sustained throughput: one non-MUL/DIV op per 3 cycles.
- req_* changes while not ready are ignored. Operands used are those present at the accept edge.
- DIV by zero: no special handling; OV comes from alu_overflow, quotient and remainder are passed through.

Test Plan:
- ADD op1=0x7F, op2=0x01, psw_in=0x00 -> wb_valid at accept+3; wb_acc=0x80; wb_psw=0x44; wb_psw_we=1; wb_b_we=0.
- MUL op1=0x10, op2=0x20, psw_in=0x80 -> wb_valid at accept+6; wb_acc=0x00; wb_b=0x02; wb_b_we=1; wb_psw=0x04; req_ready=0 for cycles accept+1..+5.
- RRC op1=0x01, psw_in=0x00 -> wb_acc=0x00; wb_psw=0x80; wb_psw_we=1.
- CPL op1=0x5A, psw_in=0xC5 -> wb_acc=0xA5; wb_psw=0xC5; wb_psw_we=0; alu_* outputs stable ISSUE..CAPTURE.
- Back-to-back: ADD then INC 0xFF with req_valid held high -> second request accepted in first DONE cycle; second wb_valid 3 cycles after first, wb_acc=0x00, wb_psw_we=0.
- Reset asserted in WAIT of DIV 0x64/0x07 -> all outputs 0 immediately, no wb_valid. After release, ADD 0x01+0x02 -> wb_acc=0x03 at accept+3.
